// File: rtl/pic_irq_core.sv
// 8259-style interrupt core: IRR/ISR with edge detection, rotating or fully-nested
// priority resolution, a two-pulse INTA handshake and EOI processing.
module pic_irq_core #(
  parameter int N    = 8,
  parameter int ID_W = $clog2(N)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N-1:0]    ir,
  input  logic            level_mode,
  input  logic            auto_rotate,
  input  logic            auto_eoi,
  input  logic [N-1:0]    imr,
  input  logic            inta,
  input  logic            eoi_valid,
  input  logic            eoi_specific,
  input  logic [ID_W-1:0] eoi_id,
  output logic            int_out,
  output logic            vector_valid,
  output logic [ID_W-1:0] vector_id,
  output logic [N-1:0]    irr,
  output logic [N-1:0]    isr
);

  typedef enum logic {IDLE = 1'b0, ACK1 = 1'b1} state_t;

  typedef struct packed {
    logic            found;
    logic [ID_W-1:0] rank;
    logic [ID_W-1:0] id;
  } pick_t;

  localparam logic [ID_W-1:0] LAST_ID = ID_W'(N - 1);

  // Highest-priority set bit; rank 0 is the channel just after the lowest-priority pointer.
  function automatic pick_t pick_first(input logic [N-1:0] vec, input logic [ID_W-1:0] lo);
    pick_t res;
    int    pos;
    res = '0;
    for (int k = N - 1; k >= 0; k--) begin
      pos = int'(lo) + 1 + k;
      if (pos >= N) pos = pos - N;
      if (vec[pos[ID_W-1:0]]) begin
        res.found = 1'b1;
        res.rank  = ID_W'(k);
        res.id    = ID_W'(pos);
      end
    end
    return res;
  endfunction

  // One-hot decode; IDs at or beyond N decode to zero and are thus ignored.
  function automatic logic [N-1:0] onehot(input logic [ID_W-1:0] id);
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) begin
      v[i] = (id == ID_W'(i));
    end
    return v;
  endfunction

  state_t          state_r, state_nx_s;
  logic [N-1:0]    prev_r, irr_r, isr_r;
  logic [N-1:0]    irr_nx_s, isr_nx_s;
  logic [ID_W-1:0] lo_ptr_r, lo_ptr_nx_s;
  logic [ID_W-1:0] sel_r, sel_nx_s;
  logic            spur_r, spur_nx_s;
  logic            vv_r, vv_nx_s;
  logic [ID_W-1:0] vid_r, vid_nx_s;
  pick_t           cand_s, isr_hi_s;
  logic [N-1:0]    ack_set_s, aeoi_clr_s, eoi_req_s, eoi_clr_s;
  logic            aeoi_rot_s;
  logic [ID_W-1:0] eoi_tgt_s;

  assign cand_s   = pick_first(irr_r & ~imr, lo_ptr_r);
  assign isr_hi_s = pick_first(isr_r, lo_ptr_r);

  // Request only when the candidate outranks everything in service, never mid-handshake.
  assign int_out = (state_r == IDLE) & cand_s.found &
                   (~isr_hi_s.found | (cand_s.rank < isr_hi_s.rank));

  assign vector_valid = vv_r;
  assign vector_id    = vid_r;
  assign irr          = irr_r;
  assign isr          = isr_r;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // INTA handshake: first pulse latches the winner, second pulse presents it.
  always_comb begin
    state_nx_s = state_r;
    sel_nx_s   = sel_r;
    spur_nx_s  = spur_r;
    vv_nx_s    = 1'b0;
    vid_nx_s   = vid_r;
    ack_set_s  = '0;
    aeoi_clr_s = '0;
    aeoi_rot_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (inta) begin
          state_nx_s = ACK1;
          if (cand_s.found) begin
            sel_nx_s  = cand_s.id;
            spur_nx_s = 1'b0;
            ack_set_s = onehot(cand_s.id);
          end else begin
            sel_nx_s  = LAST_ID;
            spur_nx_s = 1'b1;
          end
        end else begin
          state_nx_s = IDLE;
        end
      end
      ACK1: begin
        if (inta) begin
          state_nx_s = IDLE;
          vv_nx_s    = 1'b1;
          vid_nx_s   = sel_r;
          if (auto_eoi && !spur_r) begin
            aeoi_clr_s = onehot(sel_r);
            aeoi_rot_s = auto_rotate;
          end else begin
            aeoi_clr_s = '0;
            aeoi_rot_s = 1'b0;
          end
        end else begin
          state_nx_s = ACK1;
        end
      end
      default: begin
        state_nx_s = IDLE;
      end
    endcase
  end

  // EOI decode and next IRR/ISR/rotation pointer; a same-cycle acknowledge set beats any clear.
  always_comb begin
    eoi_req_s = '0;
    eoi_tgt_s = isr_hi_s.id;
    if (eoi_valid) begin
      if (eoi_specific) begin
        eoi_req_s = onehot(eoi_id) & isr_r;
        eoi_tgt_s = eoi_id;
      end else if (isr_hi_s.found) begin
        eoi_req_s = onehot(isr_hi_s.id);
        eoi_tgt_s = isr_hi_s.id;
      end else begin
        eoi_req_s = '0;
      end
    end else begin
      eoi_req_s = '0;
    end
    eoi_clr_s = eoi_req_s & ~ack_set_s;
    isr_nx_s  = (isr_r & ~eoi_clr_s & ~aeoi_clr_s) | ack_set_s;
    if (level_mode) begin
      irr_nx_s = ir;
    end else begin
      irr_nx_s = (irr_r & ~ack_set_s) | (ir & ~prev_r);
    end
    if (auto_rotate && (|eoi_clr_s)) begin
      lo_ptr_nx_s = eoi_tgt_s;
    end else if (aeoi_rot_s) begin
      lo_ptr_nx_s = sel_r;
    end else begin
      lo_ptr_nx_s = lo_ptr_r;
    end
  end

  // Datapath registers; edge history resets high so lines held through reset stay quiet.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_r   <= '1;
      irr_r    <= '0;
      isr_r    <= '0;
      lo_ptr_r <= LAST_ID;
      sel_r    <= '0;
      spur_r   <= 1'b0;
      vv_r     <= 1'b0;
      vid_r    <= '0;
    end else begin
      prev_r   <= ir;
      irr_r    <= irr_nx_s;
      isr_r    <= isr_nx_s;
      lo_ptr_r <= lo_ptr_nx_s;
      sel_r    <= sel_nx_s;
      spur_r   <= spur_nx_s;
      vv_r     <= vv_nx_s;
      vid_r    <= vid_nx_s;
    end
  end

endmodule

// File: tb/tb_pic_irq_core.sv
// Directed self-checking bench for pic_irq_core (N=8) with hand-computed expectations.
module tb_pic_irq_core;
  localparam int N    = 8;
  localparam int ID_W = 3;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    ir;
  logic            level_mode, auto_rotate, auto_eoi;
  logic [N-1:0]    imr;
  logic            inta, eoi_valid, eoi_specific;
  logic [ID_W-1:0] eoi_id;
  logic            int_out, vector_valid;
  logic [ID_W-1:0] vector_id;
  logic [N-1:0]    irr, isr;

  int checks = 0;
  int errors = 0;

  pic_irq_core #(.N(N), .ID_W(ID_W)) dut (
    .clk(clk), .reset(reset), .ir(ir), .level_mode(level_mode),
    .auto_rotate(auto_rotate), .auto_eoi(auto_eoi), .imr(imr), .inta(inta),
    .eoi_valid(eoi_valid), .eoi_specific(eoi_specific), .eoi_id(eoi_id),
    .int_out(int_out), .vector_valid(vector_valid), .vector_id(vector_id),
    .irr(irr), .isr(isr)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; ir = '0; level_mode = 1'b0; auto_rotate = 1'b0; auto_eoi = 1'b0;
    imr = '0; inta = 1'b0; eoi_valid = 1'b0; eoi_specific = 1'b0; eoi_id = '0;
    tick(); tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic pulse_ir(input logic [N-1:0] m);
    ir = m;
    tick();
    ir = '0;
  endtask

  task automatic ack(input logic [ID_W-1:0] exp_id, input string tag);
    inta = 1'b1; tick(); inta = 1'b0;
    check_eq({tag, "_int_in_ack1"}, 32'(int_out), 32'd0);
    tick();
    inta = 1'b1; tick(); inta = 1'b0;
    check_eq({tag, "_vv"}, 32'(vector_valid), 32'd1);
    check_eq({tag, "_vid"}, 32'(vector_id), 32'(exp_id));
    tick();
    check_eq({tag, "_vv_drop"}, 32'(vector_valid), 32'd0);
  endtask

  task automatic do_eoi(input logic spec, input logic [ID_W-1:0] id);
    eoi_valid = 1'b1; eoi_specific = spec; eoi_id = id;
    tick();
    eoi_valid = 1'b0; eoi_specific = 1'b0;
  endtask

  initial begin
    do_reset();
    check_eq("rst_irr", 32'(irr), 32'h00);
    check_eq("rst_isr", 32'(isr), 32'h00);
    check_eq("rst_int", 32'(int_out), 32'd0);
    check_eq("rst_vv", 32'(vector_valid), 32'd0);
    check_eq("rst_vid", 32'(vector_id), 32'd0);

    // Basic edge request and acknowledge on channel 3.
    pulse_ir(8'h08);
    check_eq("e3_irr", 32'(irr), 32'h08);
    check_eq("e3_int", 32'(int_out), 32'd1);
    ack(3'd3, "e3");
    check_eq("e3_isr", 32'(isr), 32'h08);
    check_eq("e3_irr_clr", 32'(irr), 32'h00);

    // Fully nested: ch2 in service blocks ch5, ch1 preempts.
    do_reset();
    pulse_ir(8'h04);
    ack(3'd2, "n2");
    check_eq("n_isr2", 32'(isr), 32'h04);
    pulse_ir(8'h20);
    check_eq("n_ch5_blocked", 32'(int_out), 32'd0);
    pulse_ir(8'h02);
    check_eq("n_ch1_int", 32'(int_out), 32'd1);
    ack(3'd1, "n1");
    check_eq("n_isr21", 32'(isr), 32'h06);
    do_eoi(1'b0, 3'd0);
    check_eq("n_nseoi", 32'(isr), 32'h04);
    check_eq("n_int_after_eoi", 32'(int_out), 32'd0);
    do_eoi(1'b1, 3'd2);
    check_eq("n_seoi", 32'(isr), 32'h00);
    check_eq("n_ch5_now", 32'(int_out), 32'd1);

    // Automatic rotation: after EOI of ch0, ch1 outranks ch0.
    do_reset();
    auto_rotate = 1'b1;
    pulse_ir(8'h03);
    check_eq("r_irr", 32'(irr), 32'h03);
    ack(3'd0, "r0");
    check_eq("r_int_blocked", 32'(int_out), 32'd0);
    do_eoi(1'b0, 3'd0);
    check_eq("r_isr_clr", 32'(isr), 32'h00);
    pulse_ir(8'h01);
    check_eq("r_irr2", 32'(irr), 32'h03);
    ack(3'd1, "r1");
    check_eq("r_isr1", 32'(isr), 32'h02);
    check_eq("r_irr_ch0", 32'(irr), 32'h01);
    do_eoi(1'b0, 3'd0);
    ack(3'd0, "r0b");

    // Auto-EOI with rotation: ch5 cleared at second INTA, ch6 then outranks ch0.
    do_reset();
    auto_eoi = 1'b1; auto_rotate = 1'b1;
    pulse_ir(8'h20);
    ack(3'd5, "a5");
    check_eq("a_isr", 32'(isr), 32'h00);
    pulse_ir(8'h41);
    ack(3'd6, "a6");

    // Level mode: request withdrawn before INTA gives a spurious vector 7.
    do_reset();
    level_mode = 1'b1;
    ir = 8'h10; tick();
    check_eq("l_irr", 32'(irr), 32'h10);
    check_eq("l_int", 32'(int_out), 32'd1);
    ir = 8'h00; tick();
    check_eq("l_irr_drop", 32'(irr), 32'h00);
    ack(3'd7, "lspur");
    check_eq("l_isr", 32'(isr), 32'h00);

    // Masking applies at the resolver only.
    do_reset();
    imr = 8'h01;
    pulse_ir(8'h01);
    check_eq("m_irr", 32'(irr), 32'h01);
    check_eq("m_int", 32'(int_out), 32'd0);
    imr = 8'h00; #1;
    check_eq("m_unmask", 32'(int_out), 32'd1);

    // New edge on the channel being acknowledged: set wins in IRR.
    do_reset();
    pulse_ir(8'h40);
    tick();
    ir = 8'h40; inta = 1'b1; tick(); ir = 8'h00; inta = 1'b0;
    check_eq("s_irr", 32'(irr), 32'h40);
    check_eq("s_isr", 32'(isr), 32'h40);
    inta = 1'b1; tick(); inta = 1'b0;
    check_eq("s_vid", 32'(vector_id), 32'd6);

    // Reset mid-handshake, with a line held high through reset.
    do_reset();
    pulse_ir(8'h08);
    inta = 1'b1; tick(); inta = 1'b0;
    check_eq("x_isr_pre", 32'(isr), 32'h08);
    ir = 8'h10;
    #2 reset = 1'b1;
    #1;
    check_eq("x_isr", 32'(isr), 32'h00);
    check_eq("x_irr", 32'(irr), 32'h00);
    check_eq("x_int", 32'(int_out), 32'd0);
    check_eq("x_vv", 32'(vector_valid), 32'd0);
    tick(); tick();
    reset = 1'b0;
    tick();
    check_eq("x_irr_held", 32'(irr), 32'h00);
    check_eq("x_int_held", 32'(int_out), 32'd0);
    inta = 1'b1; tick(); inta = 1'b0;
    check_eq("x_idle_vv", 32'(vector_valid), 32'd0);
    inta = 1'b1; tick(); inta = 1'b0;
    check_eq("x_spur_vv", 32'(vector_valid), 32'd1);
    check_eq("x_spur_vid", 32'(vector_id), 32'd7);
    ir = 8'h00;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
